// File: rtl/snn_spike_pkg.sv
// Shared types for spike-train encoders and neuron networks: encoder state,
// p/n spike pair and the sigma-delta firing threshold.
package snn_spike_pkg;

  typedef enum logic {
    ENC_IDLE   = 1'b0,
    ENC_ENCODE = 1'b1
  } enc_state_t;

  typedef struct packed {
    logic data;
    logic sign;
  } spike_t;

  // Firing threshold for a signed sample of data_w bits: 2^(data_w-1).
  function automatic int unsigned spike_thresh(input int unsigned data_w);
    return 32'd1 << (data_w - 32'd1);
  endfunction

endpackage

// File: rtl/real_data_encoder_if.sv
// Sample handshake plus spike/status outputs of the real-valued spike encoder.
interface real_data_encoder_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WIN_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [WIN_W-1:0]  window;
  logic              p_out;
  logic              n_out;
  logic              busy;
  logic              done;

  modport master (
    output in_valid, in_data, window,
    input  in_ready, p_out, n_out, busy, done
  );

  modport slave (
    input  in_valid, in_data, window,
    output in_ready, p_out, n_out, busy, done
  );
endinterface

// File: rtl/real_data_encoder.sv
// Rate-encodes signed samples into p/n spike trains with a first-order
// sigma-delta accumulator over a per-sample programmable window.
module real_data_encoder
  import snn_spike_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WIN_W  = 8
) (
  input logic                clk,
  input logic                rst,
  real_data_encoder_if.slave bus
);

  localparam int unsigned SUM_W = DATA_W + 1;
  localparam logic [SUM_W-1:0] THRESH = SUM_W'(spike_thresh(DATA_W));

  enc_state_t        state;
  logic              sign;
  logic [DATA_W-1:0] mag;
  logic [DATA_W-1:0] acc;
  logic [WIN_W-1:0]  win;
  logic [WIN_W-1:0]  step;
  logic              p_q;
  logic              n_q;
  logic              done_q;

  logic [DATA_W-1:0] mag_in_c;
  logic [DATA_W:0]   step_res_c;
  logic [DATA_W-1:0] acc_next_c;
  logic [WIN_W-1:0]  step_next_c;
  spike_t            spike_c;

  // One sigma-delta step: returns {fire, next accumulator}. The residue after
  // a fire is always below THRESH, so it fits back into DATA_W bits.
  function automatic logic [DATA_W:0] sd_step(input logic [DATA_W-1:0] acc_cur,
                                               input logic [DATA_W-1:0] mag_cur);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, acc_cur} + {1'b0, mag_cur};
    if (sum >= THRESH) begin
      return {1'b1, DATA_W'(sum - THRESH)};
    end
    return {1'b0, DATA_W'(sum)};
  endfunction

  // Magnitude as unsigned DATA_W bits; the most negative sample maps to THRESH.
  always_comb begin
    mag_in_c = bus.in_data;
    if (bus.in_data[DATA_W-1]) begin
      mag_in_c = (~bus.in_data) + DATA_W'(1);
    end
  end

  always_comb begin
    step_res_c   = sd_step(acc, mag);
    acc_next_c   = step_res_c[DATA_W-1:0];
    spike_c.data = step_res_c[DATA_W];
    spike_c.sign = sign;
    step_next_c  = step + WIN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ENC_IDLE;
      sign   <= 1'b0;
      mag    <= '0;
      acc    <= '0;
      win    <= '0;
      step   <= '0;
      p_q    <= 1'b0;
      n_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      p_q    <= 1'b0;
      n_q    <= 1'b0;
      done_q <= 1'b0;
      case (state)
        ENC_IDLE: begin
          if (bus.in_valid) begin
            sign <= bus.in_data[DATA_W-1];
            mag  <= mag_in_c;
            win  <= bus.window;
            acc  <= '0;
            step <= '0;
            // An empty window completes immediately without leaving IDLE.
            if (bus.window == '0) begin
              done_q <= 1'b1;
            end else begin
              state <= ENC_ENCODE;
            end
          end
        end
        ENC_ENCODE: begin
          acc  <= acc_next_c;
          step <= step_next_c;
          p_q  <= spike_c.data & ~spike_c.sign;
          n_q  <= spike_c.data & spike_c.sign;
          if (step_next_c == win) begin
            done_q <= 1'b1;
            state  <= ENC_IDLE;
          end
        end
        default: state <= ENC_IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state == ENC_IDLE);
  assign bus.busy     = (state == ENC_ENCODE);
  assign bus.p_out    = p_q;
  assign bus.n_out    = n_q;
  assign bus.done     = done_q;

endmodule

// File: doc/real_data_encoder.md
# real_data_encoder

Converts signed real-valued samples into positive/negative spike trains (data/sign pulse pairs) that drive the input side of the neuron networks. It is the transmitter for the `p_in_*`/`n_in_*` spike inputs consumed by `neuron`-based networks. It accepts one sample per valid/ready handshake, rate-encodes its magnitude over a programmable window using a first-order sigma-delta accumulator, and pulses `done` when the window ends.

## Interface
Parameters:
- `DATA_W`, default 8: signed sample width. Spike threshold `THRESH` = 2^(DATA_W-1).
- `WIN_W`, default 8: width of the window length.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: sample offered.
- `in_ready`, out, 1: encoder idle and can accept a sample.
- `in_data`, in, DATA_W: signed two's-complement sample.
- `window`, in, WIN_W: number of encode steps. Sampled only on accept.
- `p_out`, out, 1: positive spike; connects to a `p_in_*`.
- `n_out`, out, 1: negative spike; connects to an `n_in_*`.
- `busy`, out, 1: an encode is in progress.
- `done`, out, 1: one-cycle pulse when the window completes.

## Operation
- States are IDLE and ENCODE.
- `in_ready` = (state == IDLE). `busy` = (state == ENCODE).
- Accept happens on any edge with `in_valid && in_ready`. On accept:
  - latch `sign` = `in_data[DATA_W-1]`;
  - latch `mag` = |in_data|, DATA_W bits unsigned, so −2^(DATA_W-1) gives exactly THRESH;
  - latch `win` = `window`;
  - set `acc` to 0 and `step` to 0.
- If `window` == 0 on accept: stay in IDLE, emit no spikes, and assert `done` for the next cycle.
- Otherwise go to ENCODE. On each ENCODE edge:
  - `sum` = `acc` + `mag`, DATA_W+1 bits;
  - if `sum` ≥ THRESH: fire and set `acc` = `sum` − THRESH; otherwise set `acc` = `sum` with no fire;
  - `p_out` ≤ fire & ~sign, and `n_out` ≤ fire & sign. The two are never high together;
  - `step` increments. On the edge where `step` reaches `win`: set `done` ≤ 1 and go to IDLE.
- Spike count over one window = floor(mag·win / THRESH).
- A zero sample produces no spikes. mag == THRESH fires on every step.
- `in_valid` while busy is ignored: no latch, and `in_data` is not sampled.
- In IDLE, `p_out` and `n_out` are registered to 0. `done` is high for exactly one cycle per accepted sample.
- Reset, including mid-window:
  - state goes to IDLE; `acc`, `step`, `p_out`, `n_out` and `done` clear to 0;
  - `in_ready` is 1 and `busy` is 0 from the first edge with `rst` high;
  - the aborted window produces no `done`.
  - `rst` has priority over accept.

## Timing
- Accept on edge E0. Step k is evaluated on edge Ek, for k = 1..win.
- Spike k is visible in the cycle after Ek. Spike latency from accept is therefore 1 cycle.
- `done` is visible in the same cycle as the last spike, which follows E(win).
- `in_ready` rises in that same cycle, so the next accept can happen at E(win+1). Steady-state throughput is one sample per win+1 cycles.
- With `window` == 0, `done` is visible in the cycle after E0, and `in_ready` stays 1, allowing a back-to-back accept.
- All outputs except `in_ready` and `busy` are registered. Those two decode directly from the state register.

## Structure
- Put these in the shared package `snn_spike_pkg`:
  - a state enum (`ENC_IDLE`, `ENC_ENCODE`);
  - a `spike_t` struct (`data`, `sign`) for p/n pairs;
  - a helper function for THRESH.
- The design is a single module with no sub-module. The accumulator step is an inline function, so keep it in one file.

## Test plan
- `in_data`=64, `window`=8 → `p_out` high on steps 2, 4, 6, 8 (4 spikes), `n_out` never high, `done` coincident with step 8.
- `in_data`=−128, `window`=5 → `n_out` high for 5 consecutive cycles, `p_out` 0, `done` on the 5th cycle.
- `in_data`=127, `window`=128 → exactly 127 `p_out` pulses. `in_data`=0, `window`=10 → 0 pulses with `done` after 10 steps.
- `window`=0 → `done` the cycle after accept with no spikes. A second sample offered the next cycle is accepted immediately.
- `in_valid` held high with changing `in_data` during ENCODE → no re-accept and no change in spike count. The next accept is at E(win+1) with the new data.
- `rst` asserted at step 3 of an 8-step window → outputs 0 and `in_ready`=1 the next cycle, and no `done` pulse.
